// File: rtl/tube_scan_ctrl.sv
// Multiplexed 7-segment scan controller: two 4-digit banks plus one single-digit tube,
// bus-written staging registers that are copied to the display only at frame boundaries.
module tube_scan_ctrl #(
  parameter int SCAN_DIV = 25000,
  parameter int BLANK    = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [7:0]  o_digital_tube0,
  output logic [3:0]  o_digital_tube_sel0,
  output logic [7:0]  o_digital_tube1,
  output logic [3:0]  o_digital_tube_sel1,
  output logic [7:0]  o_digital_tube2,
  output logic        o_digital_tube_sel2
);

  localparam int                CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_CNT = CNT_W'(BLANK);

  logic [31:0]      r_data;
  logic [3:0]       r_tube2;
  logic             r_enable;
  logic [31:0]      r_act_data;
  logic [3:0]       r_act_tube2;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;

  logic [3:0]       w_sel;
  logic [3:0]       w_low_digit;
  logic [3:0]       w_high_digit;
  logic             w_blank;

  function automatic logic [7:0] hexSeg(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // Staging writes and the scan counter share one edge; the active copy takes the
  // pre-edge staging value, so a write on the boundary waits a whole frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data      <= '0;
      r_tube2     <= '0;
      r_enable    <= 1'b1;
      r_act_data  <= '0;
      r_act_tube2 <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
    end else begin
      if (i_we) begin
        case (i_addr)
          2'd0:    r_data   <= i_wdata;
          2'd1:    r_tube2  <= i_wdata[3:0];
          2'd2:    r_enable <= i_wdata[0];
          default: ;
        endcase
      end
      if (!r_enable) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_act_data  <= r_data;
          r_act_tube2 <= r_tube2;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_sel        = 4'b0001 << r_idx;
  assign w_low_digit  = r_act_data[{1'b0, r_idx, 2'b00} +: 4];
  assign w_high_digit = r_act_data[{1'b1, r_idx, 2'b00} +: 4];
  assign w_blank      = (r_cnt < BLANK_CNT);

  // Display drive depends only on registered state; the banks go dark at the start
  // of every slot so the previous digit does not ghost onto the new select.
  always_comb begin
    o_digital_tube_sel0 = 4'b0000;
    o_digital_tube_sel1 = 4'b0000;
    o_digital_tube_sel2 = 1'b0;
    o_digital_tube0     = 8'hFF;
    o_digital_tube1     = 8'hFF;
    o_digital_tube2     = 8'hFF;
    if (r_enable) begin
      o_digital_tube_sel0 = w_sel;
      o_digital_tube_sel1 = w_sel;
      o_digital_tube_sel2 = 1'b1;
      o_digital_tube2     = hexSeg(r_act_tube2);
      if (!w_blank) begin
        o_digital_tube0 = hexSeg(w_low_digit);
        o_digital_tube1 = hexSeg(w_high_digit);
      end
    end
  end

  always_comb begin
    o_rdata = 32'h0;
    case (i_addr)
      2'd0:    o_rdata = r_data;
      2'd1:    o_rdata = {28'h0, r_tube2};
      2'd2:    o_rdata = {31'h0, r_enable};
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Randomized bench for tube_scan_ctrl: a frame-time reference model predicts every
// cycle's outputs into a scoreboard queue that an independent monitor drains.
module tb_tube_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLNK  = 2;
  localparam int FRAME = 4 * DIV;
  localparam int NCYC  = 3000;

  typedef struct {
    logic [3:0]  sel0;
    logic [3:0]  sel1;
    logic        sel2;
    logic [7:0]  tube0;
    logic [7:0]  tube1;
    logic [7:0]  tube2;
    logic [31:0] rdata;
  } expT;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tube0, tube1, tube2;
  logic [3:0]  sel0, sel1;
  logic        sel2;

  int  total = 0;
  int  bad   = 0;
  bit  running = 1'b0;
  expT expQ[$];

  // Reference model: scan position is simply "cycles since scanning (re)started" mod frame.
  int          mTime;
  bit          mEn;
  logic [31:0] mStage, mAct;
  logic [3:0]  mStage2, mAct2;
  logic [7:0]  segTab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  tube_scan_ctrl #(.SCAN_DIV(DIV), .BLANK(BLNK)) dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_we                (we),
    .i_addr              (addr),
    .i_wdata             (wdata),
    .o_rdata             (rdata),
    .o_digital_tube0     (tube0),
    .o_digital_tube_sel0 (sel0),
    .o_digital_tube1     (tube1),
    .o_digital_tube_sel1 (sel1),
    .o_digital_tube2     (tube2),
    .o_digital_tube_sel2 (sel2)
  );

  always #5 clk = ~clk;

  task automatic modelEdge(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
    if (r) begin
      mStage = 0; mStage2 = 0; mAct = 0; mAct2 = 0; mEn = 1'b1; mTime = 0;
    end else begin
      if (mEn && (mTime % FRAME == FRAME - 1)) begin
        mAct  = mStage;
        mAct2 = mStage2;
      end
      mTime = mEn ? (mTime + 1) % FRAME : 0;
      if (w) begin
        if (a == 2'd0) mStage = d;
        else if (a == 2'd1) mStage2 = d[3:0];
        else if (a == 2'd2) mEn = d[0];
      end
    end
  endtask

  function automatic expT predict(input logic [1:0] a);
    expT e;
    int slot, cnt;
    slot = mTime / DIV;
    cnt  = mTime % DIV;
    e.sel0 = 4'b0000; e.sel1 = 4'b0000; e.sel2 = 1'b0;
    e.tube0 = 8'hFF; e.tube1 = 8'hFF; e.tube2 = 8'hFF;
    if (mEn) begin
      e.sel0  = 4'(1 << slot);
      e.sel1  = e.sel0;
      e.sel2  = 1'b1;
      e.tube2 = segTab[mAct2];
      if (cnt >= BLNK) begin
        e.tube0 = segTab[(mAct >> (4 * slot)) & 32'hF];
        e.tube1 = segTab[(mAct >> (4 * slot + 16)) & 32'hF];
      end
    end
    case (a)
      2'd0:    e.rdata = mStage;
      2'd1:    e.rdata = {28'h0, mStage2};
      2'd2:    e.rdata = {31'h0, mEn};
      default: e.rdata = 32'h0;
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input int c);
    logic [1:0] nAddr;
    logic [31:0] nData;
    modelEdge(reset, we, addr, wdata);
    nAddr = 2'($urandom_range(0, 3));
    nData = $urandom;
    if (nAddr == 2'd2) nData[0] = ($urandom_range(0, 7) != 0);
    reset = (c < 2) || (c == 1500) || ($urandom_range(0, 599) == 0);
    we    = (c >= 2) && ($urandom_range(0, 3) == 0);
    addr  = nAddr;
    wdata = nData;
    expQ.push_back(predict(nAddr));
    running = 1'b1;
  endtask

  task automatic compareField(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput(input expT e);
    compareField("sel0",  {28'h0, sel0},  {28'h0, e.sel0});
    compareField("sel1",  {28'h0, sel1},  {28'h0, e.sel1});
    compareField("sel2",  {31'h0, sel2},  {31'h0, e.sel2});
    compareField("tube0", {24'h0, tube0}, {24'h0, e.tube0});
    compareField("tube1", {24'h0, tube1}, {24'h0, e.tube1});
    compareField("tube2", {24'h0, tube2}, {24'h0, e.tube2});
    compareField("rdata", rdata, e.rdata);
  endtask

  // Monitor: the display presents a new state every cycle, so one expectation is consumed per cycle.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #2;
      if (running) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL scoreboard: got empty queue expected an entry at %0t", $time);
        end else begin
          e = expQ.pop_front();
          checkOutput(e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 32'h0;
    $display("[TB] starting %0d randomized cycles", NCYC);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      applyStimulus(c);
    end
    @(posedge clk);
    #1;
    running = 1'b0;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d leftover entries expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
